// File: rtl/star_pkg.sv
// star_pkg: shared FSM states, scoring constants and score ceiling for star collection.
package star_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FLASH = 2'd1, CLEAR = 2'd2} state_t;
    localparam int PTS_IDLE = 10;
    localparam int PTS_FLASH = 20;
    localparam logic [11:0] SCORE_MAX = 12'h990;
endpackage

// File: rtl/bcd_add_sat.sv
// bcd_add_sat: two-digit (hundreds/tens) BCD adder that saturates at the score ceiling.
module bcd_add_sat
    import star_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    logic [4:0] t;
    logic [4:0] h;
    logic       c;
    always_comb begin
        t = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        c = t > 5'd9;
        h = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c};
        sum = (h > 5'd9) ? SCORE_MAX[11:4] : {h[3:0], c ? 4'(t - 5'd10) : t[3:0]};
    end
endmodule

// File: rtl/star_collect_ctrl.sv
// star_collect_ctrl: tracks collected stars, BCD score with combo bonus, and the
// IDLE/FLASH/CLEAR flash-window state machine.
module star_collect_ctrl
    import star_pkg::*;
#(
    parameter int NUM_STARS    = 8,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                 sys_clk,
    input  logic                 RST_N,
    input  logic [NUM_STARS-1:0] touch_star,
    input  logic                 frame_tick,
    input  logic                 level_restart,
    output logic [NUM_STARS-1:0] collected_mask,
    output logic [3:0]           star_count,
    output logic [11:0]          score_bcd,
    output logic                 star_event,
    output logic                 flash_active,
    output logic                 all_collected
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    state_t               state, state_nx;
    logic [CW-1:0]        flash_cnt, flash_cnt_nx;
    logic [NUM_STARS-1:0] new_hits, mask_nx;
    logic [7:0]           n, add_tens, add_bcd, score_sum;

    assign new_hits = (state == CLEAR) ? '0 : touch_star & ~collected_mask;
    assign mask_nx  = collected_mask | new_hits;

    always_comb begin
        n = '0;
        for (int i = 0; i < NUM_STARS; i++) n = n + 8'(new_hits[i]);
    end

    // Points are whole tens, so the adder only ever sees the tens/hundreds digits.
    assign add_tens = n * ((state == FLASH) ? 8'(PTS_FLASH / 10) : 8'(PTS_IDLE / 10));
    assign add_bcd  = (add_tens > 8'd99) ? 8'h99 : {4'(add_tens / 8'd10), 4'(add_tens % 8'd10)};

    bcd_add_sat u_add (
        .a  (score_bcd[11:4]),
        .b  (add_bcd),
        .sum(score_sum)
    );

    always_comb begin
        state_nx     = state;
        flash_cnt_nx = flash_cnt;
        if (level_restart) begin
            state_nx     = IDLE;
            flash_cnt_nx = '0;
        end else if (state != CLEAR) begin
            if (&mask_nx) begin
                state_nx     = CLEAR;
                flash_cnt_nx = '0;
            end else if (|new_hits) begin
                state_nx     = FLASH;
                flash_cnt_nx = CW'(FLASH_FRAMES);
            end else if (state == FLASH && frame_tick) begin
                flash_cnt_nx = flash_cnt - CW'(1);
                state_nx     = (flash_cnt == CW'(1)) ? IDLE : FLASH;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            flash_cnt      <= '0;
            collected_mask <= '0;
            star_count     <= '0;
            score_bcd      <= '0;
            star_event     <= 1'b0;
        end else begin
            state     <= state_nx;
            flash_cnt <= flash_cnt_nx;
            if (level_restart) begin
                collected_mask <= '0;
                star_count     <= '0;
                score_bcd      <= '0;
                star_event     <= 1'b0;
            end else begin
                collected_mask <= mask_nx;
                star_count     <= star_count + 4'(n);
                score_bcd      <= {score_sum, 4'h0};
                star_event     <= |new_hits;
            end
        end
    end

    assign flash_active  = state == FLASH;
    assign all_collected = state == CLEAR;
endmodule

// File: doc/star_collect_ctrl.md
STAR_COLLECT_CTRL -- requirements
Module: star_collect_ctrl

Interface
REQ-001 SHALL have parameter NUM_STARS, default 8: number of star objects tracked (touch_star width).
REQ-002 SHALL have parameter FLASH_FRAMES, default 30: length of the collection flash / combo window, in frames.
REQ-003 SHALL have port sys_clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port touch_star, input, NUM_STARS: per-star touch pulses from the star objects; bit i belongs to star i.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 SHALL have port level_restart, input, 1: synchronous clear of all collection state.
REQ-008 SHALL have port collected_mask, output, NUM_STARS: bit i is 1 once star i has been collected.
REQ-009 SHALL have port star_count, output, 4: number of collected stars, 0..NUM_STARS.
REQ-010 SHALL have port score_bcd, output, 12: three BCD digits (hundreds, tens, units); units digit is always 0.
REQ-011 SHALL have port star_event, output, 1: one-cycle pulse when at least one new star is collected.
REQ-012 SHALL have port flash_active, output, 1: high while the state machine is in FLASH.
REQ-013 SHALL have port all_collected, output, 1: sticky; high in CLEAR.

Function
REQ-014 SHALL compute new_hits = touch_star & ~collected_mask each cycle, so each star is counted at most once regardless of pulse length or repeats.
REQ-015 SHALL set the collected_mask bits for new_hits on the next rising edge; collected_mask, star_count, score_bcd and star_event SHALL update in that same edge (latency 1 cycle).
REQ-016 SHALL handle simultaneous hits: n = popcount(new_hits), 0..NUM_STARS; star_count += n.
REQ-017 SHALL score per star 10 points outside the combo window (IDLE) and 20 points inside it (FLASH); total added = n*10 or n*20.
REQ-018 SHALL perform BCD addition on the tens/hundreds digits with carry and saturate score_bcd at 12'h990.
REQ-019 SHALL run the FSM with states IDLE, FLASH and CLEAR.
REQ-020 SHALL transition IDLE->FLASH when new_hits != 0 and load flash_cnt = FLASH_FRAMES.
REQ-021 SHALL, in FLASH, decrement flash_cnt on frame_tick; flash_cnt reaching 0 SHALL return the FSM to IDLE.
REQ-022 SHALL, in FLASH, reload flash_cnt to FLASH_FRAMES on new hits; the hit SHALL take priority over a same-cycle frame_tick.
REQ-023 SHALL enter CLEAR from any state when the next collected_mask is all ones; CLEAR overrides the entry into FLASH.
REQ-024 SHALL, in CLEAR, ignore touch_star and frame_tick; only level_restart or reset SHALL exit CLEAR.
REQ-025 SHALL, on level_restart, go to IDLE and zero the mask, count, score, flash_cnt and star_event; level_restart SHALL take priority over a simultaneous hit.
REQ-026 SHALL drive star_event low in the cycle following a hit unless another new hit occurred.

Reset
REQ-027 SHALL, on RST_N low (asynchronous), reset the FSM to IDLE and set collected_mask=0, star_count=0, score_bcd=12'h000, flash_cnt=0, star_event=0, flash_active=0 and all_collected=0.
REQ-028 SHALL apply reset mid-FLASH or in CLEAR with the same effect as at power-up; the first edge after release SHALL behave as a normal IDLE cycle.

Structure
REQ-029 SHALL put the FSM state encodings, the points constants (10, 20) and the score saturation value 12'h990 in shared package star_pkg.
REQ-030 SHALL implement the saturating two-digit BCD adder as one sub-module, bcd_add_sat, instanced once.

Verification
REQ-031 SHALL cover a single hit: touch_star=8'h01 for 1 cycle in IDLE -> the next edge gives mask=01, count=1, score=12'h010, star_event 1 cycle, flash_active=1.
REQ-032 SHALL cover a repeated/held hit: touch_star=8'h01 held 5 cycles -> count stays 1, score stays 12'h010, only one star_event.
REQ-033 SHALL cover a combo with a simultaneous hit: 8'h01, then 8'h06 three frames later -> count=3, score=12'h050, flash_cnt reloaded to 30.
REQ-034 SHALL cover flash expiry: one hit, then 30 frame_ticks -> flash_active drops after the 30th tick and the FSM is in IDLE; a hit then scores 10.
REQ-035 SHALL cover the all-stars case: touch_star=8'hFF in one cycle -> count=8, score=12'h080, all_collected=1; later touches are ignored until level_restart, which zeroes all outputs.
REQ-036 SHALL cover reset mid-FLASH: RST_N asserted asynchronously between edges -> all outputs go to their reset values immediately.
